// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and data access (data first, fetch starvation guard).
// Optional bus-timeout watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 15
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fetch_req_i,
  input  logic [ADDR_W-1:0] Fetch_addr_i,
  output logic [31:0]       Fetch_data_o,
  output logic              Fetch_valid_o,
  input  logic              Data_req_i,
  input  logic              Data_we_i,
  input  logic [ADDR_W-1:0] Data_addr_i,
  input  logic [31:0]       Data_wdata_i,
  input  logic [3:0]        Data_be_i,
  output logic [31:0]       Data_rdata_o,
  output logic              Data_valid_o,
  output logic              Mem_req_o,
  output logic              Mem_we_o,
  output logic [ADDR_W-1:0] Mem_addr_o,
  output logic [31:0]       Mem_wdata_o,
  output logic [3:0]        Mem_be_o,
  input  logic              Mem_ack_i,
  input  logic [31:0]       Mem_rdata_i,
  output logic              Stall_if_o,
  output logic              Stall_mem_o,
  output logic              Bus_err_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

  localparam logic [31:0] NOP_INSN   = 32'h00000013;
  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        fetch_data_q, fetch_data_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [31:0]        data_rdata_q, data_rdata_d;
  logic               data_valid_q, data_valid_d;
  logic [2:0]         starve_q, starve_d;
  logic               starved, grant_data, grant_fetch;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [3:0] WAIT_LIM = 4'(TIMEOUT - 1);
  logic [3:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
`endif

  // Fetch overrides data only once it has watched STARVE_MAX data grants go by.
  assign starved     = Fetch_req_i && (starve_q == STARVE_LIM);
  assign grant_data  = Data_req_i && !starved;
  assign grant_fetch = Fetch_req_i && !grant_data;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_valid_d  = 1'b0;
    starve_d      = starve_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d        = '0;
    bus_err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!Fetch_req_i) begin
          starve_d = '0;
        end
        if (grant_data) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = Data_we_i;
          mem_addr_d  = Data_addr_i;
          mem_wdata_d = Data_wdata_i;
          mem_be_d    = Data_we_i ? Data_be_i : 4'hF;
          if (Fetch_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (grant_fetch) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = Fetch_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
          starve_d    = '0;
        end
      end
      FETCH, DATA: begin
        if (Mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == FETCH) begin
            fetch_data_d  = Mem_rdata_i;
            fetch_valid_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            if (!mem_we_q) begin
              data_rdata_d = Mem_rdata_i;
            end
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Abandon the access: fetch sees a NOP, a load sees zero.
        else if (wait_q == WAIT_LIM) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == FETCH) begin
            fetch_data_d  = NOP_INSN;
            fetch_valid_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            if (!mem_we_q) begin
              data_rdata_d = '0;
            end
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      fetch_data_q  <= NOP_INSN;
      fetch_valid_q <= 1'b0;
      data_rdata_q  <= '0;
      data_valid_q  <= 1'b0;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      data_rdata_q  <= data_rdata_d;
      data_valid_q  <= data_valid_d;
      starve_q      <= starve_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign Bus_err_o = bus_err_q;
`else
  assign Bus_err_o = 1'b0;
`endif

  assign Mem_req_o     = mem_req_q;
  assign Mem_we_o      = mem_we_q;
  assign Mem_addr_o    = mem_addr_q;
  assign Mem_wdata_o   = mem_wdata_q;
  assign Mem_be_o      = mem_be_q;
  assign Fetch_data_o  = fetch_data_q;
  assign Fetch_valid_o = fetch_valid_q;
  assign Data_rdata_o  = data_rdata_q;
  assign Data_valid_o  = data_valid_q;
  assign Stall_if_o    = Fetch_req_i & ~fetch_valid_q;
  assign Stall_mem_o   = Data_req_i & ~data_valid_q;

endmodule
